// File: rtl/grid_gfx_pkg.sv
// Shared graphics constants for the grid sprite renderer: object codes,
// player-state codes and the reserved colors.
package grid_gfx_pkg;

  typedef enum logic [3:0] {
    G_EMPTY        = 4'd0,
    G_WALL         = 4'd1,
    G_CRATE        = 4'd2,
    G_FIRE         = 4'd3,
    G_WATER        = 4'd4,
    G_EXTINGUISHER = 4'd5
  } obj_code_e;

  typedef enum logic [3:0] {
    P_NONE  = 4'd0,
    P_IDLE  = 4'd1,
    P_WALK  = 4'd2,
    P_SPRAY = 4'd3
  } player_state_e;

  localparam logic [11:0] KEY_COLOR = 12'hF0F;
  localparam logic [11:0] BAR_COLOR = 12'hFF0;

endpackage

// File: rtl/grid_sprite_renderer_if.sv
// Video timing, pixel output and sprite ROM buses of the grid renderer.
// master = timing source / ROM side, slave = renderer.
interface grid_sprite_renderer_if #(
  parameter int TILE_LOG2 = 5
);
  localparam int AW = 4 + 2*TILE_LOG2;

  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic          hsync;
  logic          vsync;
  logic          blank;
  logic [AW-1:0] obj_rom_addr;
  logic [11:0]   obj_rom_data;
  logic [AW-1:0] player_rom_addr;
  logic [11:0]   player_rom_data;
  logic [11:0]   pixel_out;
  logic          hsync_out;
  logic          vsync_out;
  logic          blank_out;

  modport master (
    output hcount, vcount, hsync, vsync, blank, obj_rom_data, player_rom_data,
    input  obj_rom_addr, player_rom_addr, pixel_out, hsync_out, vsync_out, blank_out
  );

  modport slave (
    input  hcount, vcount, hsync, vsync, blank, obj_rom_data, player_rom_data,
    output obj_rom_addr, player_rom_addr, pixel_out, hsync_out, vsync_out, blank_out
  );

endinterface

// File: rtl/grid_tile_locator.sv
// Stage 0: registered mapping of a screen pixel to grid tile column/row and
// in-tile offsets. Column/row are forced to zero outside the grid window.
module grid_tile_locator
  import grid_gfx_pkg::*;
#(
  parameter int GRID_COLS = 13,
  parameter int GRID_ROWS = 8,
  parameter int TILE_LOG2 = 5,
  parameter int ORIGIN_X  = 112,
  parameter int ORIGIN_Y  = 112
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [10:0]          hcount_i,
  input  logic [9:0]           vcount_i,
  output logic                 in_grid_o,
  output logic [10:0]          col_o,
  output logic [9:0]           row_o,
  output logic [TILE_LOG2-1:0] offx_o,
  output logic [TILE_LOG2-1:0] offy_o
);

  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + (GRID_COLS << TILE_LOG2));
  localparam logic [9:0]  Y_LO = 10'(ORIGIN_Y);
  localparam logic [9:0]  Y_HI = 10'(ORIGIN_Y + (GRID_ROWS << TILE_LOG2));

  logic [10:0]          relx;
  logic [9:0]           rely;
  logic                 in_x;
  logic                 in_y;
  logic                 in_grid_q;
  logic [10:0]          col_q;
  logic [9:0]           row_q;
  logic [TILE_LOG2-1:0] offx_q;
  logic [TILE_LOG2-1:0] offy_q;

  assign relx = hcount_i - X_LO;
  assign rely = vcount_i - Y_LO;
  // Upper bound is exclusive: the pixel at ORIGIN + size is already outside.
  assign in_x = (hcount_i >= X_LO) && (hcount_i < X_HI);
  assign in_y = (vcount_i >= Y_LO) && (vcount_i < Y_HI);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_grid_q <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      offx_q    <= '0;
      offy_q    <= '0;
    end else begin
      in_grid_q <= in_x && in_y;
      col_q     <= (in_x && in_y) ? (relx >> TILE_LOG2) : '0;
      row_q     <= (in_x && in_y) ? (rely >> TILE_LOG2) : '0;
      offx_q    <= relx[TILE_LOG2-1:0];
      offy_q    <= rely[TILE_LOG2-1:0];
    end
  end

  assign in_grid_o = in_grid_q;
  assign col_o     = col_q;
  assign row_o     = row_q;
  assign offx_o    = offx_q;
  assign offy_o    = offy_q;

endmodule

// File: rtl/grid_sprite_renderer.sv
// Three-stage tile/sprite compositor: locate tile, look up ROMs, composite.
// Optional macro GRID_TIMER_BAR_EN draws a per-tile timer bar from time_grid.
module grid_sprite_renderer #(
  parameter int          GRID_COLS   = 13,
  parameter int          GRID_ROWS   = 8,
  parameter int          TILE_LOG2   = 5,
  parameter int          ORIGIN_X    = 112,
  parameter int          ORIGIN_Y    = 112,
  parameter int          NUM_SPRITES = 16,
  parameter logic [11:0] KEY_COLOR   = grid_gfx_pkg::KEY_COLOR,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic                             clock,
  input  logic                             reset,
  grid_sprite_renderer_if.slave            vid,
  input  logic [GRID_ROWS*GRID_COLS*4-1:0] object_grid,
  input  logic [GRID_ROWS*GRID_COLS*4-1:0] time_grid,
  input  logic [10:0]                      player_x,
  input  logic [9:0]                       player_y,
  input  logic [3:0]                       player_code
);
  import grid_gfx_pkg::*;

  localparam int          NCELL  = GRID_ROWS * GRID_COLS;
  localparam int          IW     = $clog2(NCELL);
  localparam logic [4:0]  NS_LIM = 5'(NUM_SPRITES);
  localparam logic [10:0] TILE_X = 11'(1 << TILE_LOG2);
  localparam logic [9:0]  TILE_Y = 10'(1 << TILE_LOG2);

  logic [3:0]  frame_obj_q [NCELL];
  logic        vs_prev_q;
  logic        frame_latch;

  logic [10:0] s0_hcount_q;
  logic [9:0]  s0_vcount_q;
  logic        s0_hs_q, s0_vs_q, s0_blank_q, s0_valid_q;
  logic        s0_in_grid;
  logic [10:0] s0_col;
  logic [9:0]  s0_row;
  logic [TILE_LOG2-1:0] s0_offx, s0_offy;

  logic [IW-1:0] cell_idx;
  logic [3:0]    obj_code;
  logic          obj_present_d;
  logic [10:0]   ply_dx;
  logic [9:0]    ply_dy;
  logic          ply_present_d;

  logic        s1_obj_q, s1_ply_q, s1_bar_q;
  logic        s1_hs_q, s1_vs_q, s1_blank_q, s1_valid_q;

  logic [11:0] pixel_d;
  logic [11:0] pixel_q;
  logic        hsync_q, vsync_q, blank_q;

  // Falling vsync starts a frame; reset value 0 prevents a spurious latch
  // when reset is released while vsync is already low.
  assign frame_latch = vs_prev_q && !vid.vsync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vs_prev_q <= 1'b0;
      for (int i = 0; i < NCELL; i++) frame_obj_q[i] <= '0;
    end else begin
      vs_prev_q <= vid.vsync;
      if (frame_latch)
        for (int i = 0; i < NCELL; i++) frame_obj_q[i] <= object_grid[i*4 +: 4];
    end
  end

  grid_tile_locator #(
    .GRID_COLS (GRID_COLS),
    .GRID_ROWS (GRID_ROWS),
    .TILE_LOG2 (TILE_LOG2),
    .ORIGIN_X  (ORIGIN_X),
    .ORIGIN_Y  (ORIGIN_Y)
  ) u_locator (
    .clock     (clock),
    .reset     (reset),
    .hcount_i  (vid.hcount),
    .vcount_i  (vid.vcount),
    .in_grid_o (s0_in_grid),
    .col_o     (s0_col),
    .row_o     (s0_row),
    .offx_o    (s0_offx),
    .offy_o    (s0_offy)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s0_hcount_q <= '0;
      s0_vcount_q <= '0;
      s0_hs_q     <= 1'b1;
      s0_vs_q     <= 1'b1;
      s0_blank_q  <= 1'b1;
      s0_valid_q  <= 1'b0;
    end else begin
      s0_hcount_q <= vid.hcount;
      s0_vcount_q <= vid.vcount;
      s0_hs_q     <= vid.hsync;
      s0_vs_q     <= vid.vsync;
      s0_blank_q  <= vid.blank;
      s0_valid_q  <= 1'b1;
    end
  end

  assign cell_idx = IW'(32'(s0_row) * GRID_COLS + 32'(s0_col));
  assign obj_code = frame_obj_q[cell_idx];
  assign obj_present_d = s0_in_grid && (obj_code != G_EMPTY) && ({1'b0, obj_code} < NS_LIM);

  // The >= tests stop the subtraction from wrapping into a visible box.
  assign ply_dx = s0_hcount_q - player_x;
  assign ply_dy = s0_vcount_q - player_y;
  assign ply_present_d = (player_code != 4'd0)
                         && (s0_hcount_q >= player_x) && (ply_dx < TILE_X)
                         && (s0_vcount_q >= player_y) && (ply_dy < TILE_Y);

  assign vid.obj_rom_addr    = {obj_code, s0_offy, s0_offx};
  assign vid.player_rom_addr = {player_code, ply_dy[TILE_LOG2-1:0], ply_dx[TILE_LOG2-1:0]};

`ifdef GRID_TIMER_BAR_EN
  localparam logic [TILE_LOG2-1:0] BAR_ROW = TILE_LOG2'((1 << TILE_LOG2) - 2);

  logic [3:0] frame_time_q [NCELL];
  logic       bar_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCELL; i++) frame_time_q[i] <= '0;
    end else if (frame_latch) begin
      for (int i = 0; i < NCELL; i++) frame_time_q[i] <= time_grid[i*4 +: 4];
    end
  end

  assign bar_d = s0_in_grid && (s0_offy >= BAR_ROW)
                 && (8'(s0_offx) < {3'b000, frame_time_q[cell_idx], 1'b0});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) s1_bar_q <= 1'b0;
    else       s1_bar_q <= bar_d;
  end
`else
  logic unused_time;
  assign unused_time = ^time_grid;
  assign s1_bar_q    = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_obj_q   <= 1'b0;
      s1_ply_q   <= 1'b0;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
      s1_blank_q <= 1'b1;
      s1_valid_q <= 1'b0;
    end else begin
      s1_obj_q   <= obj_present_d;
      s1_ply_q   <= ply_present_d;
      s1_hs_q    <= s0_hs_q;
      s1_vs_q    <= s0_vs_q;
      s1_blank_q <= s0_blank_q;
      s1_valid_q <= s0_valid_q;
    end
  end

  always_comb begin
    pixel_d = BG_COLOR;
    if (!s1_valid_q || s1_blank_q)
      pixel_d = 12'h000;
    else if (s1_ply_q && (vid.player_rom_data != KEY_COLOR))
      pixel_d = vid.player_rom_data;
    else if (s1_bar_q)
      pixel_d = BAR_COLOR;
    else if (s1_obj_q && (vid.obj_rom_data != KEY_COLOR))
      pixel_d = vid.obj_rom_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel_q <= 12'h000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b1;
    end else begin
      pixel_q <= pixel_d;
      hsync_q <= s1_hs_q;
      vsync_q <= s1_vs_q;
      blank_q <= s1_blank_q || !s1_valid_q;
    end
  end

  assign vid.pixel_out = pixel_q;
  assign vid.hsync_out = hsync_q;
  assign vid.vsync_out = vsync_q;
  assign vid.blank_out = blank_q;

endmodule

// File: tb/tb_grid_sprite_renderer.sv
// Directed bench for grid_sprite_renderer with hand-computed pixel values.
module tb_grid_sprite_renderer;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [415:0] object_grid;
  logic [415:0] time_grid;
  logic [10:0]  player_x;
  logic [9:0]   player_y;
  logic [3:0]   player_code;
  logic [11:0]  ply_val;
  logic [13:0]  exp_addr;
  int           checks = 0;
  int           errors = 0;

  grid_sprite_renderer_if #(.TILE_LOG2(5)) vid();

  grid_sprite_renderer #(
    .NUM_SPRITES (8),
    .BG_COLOR    (12'h00A)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .vid         (vid),
    .object_grid (object_grid),
    .time_grid   (time_grid),
    .player_x    (player_x),
    .player_y    (player_y),
    .player_code (player_code)
  );

  always #5 clock = ~clock;

  // Sprite ROMs, one-cycle read latency
  always @(posedge clock) begin
    case (vid.obj_rom_addr[13:10])
      4'd3:    vid.obj_rom_data <= 12'h123;
      4'd6:    vid.obj_rom_data <= 12'h456;
      4'd15:   vid.obj_rom_data <= 12'h777;
      default: vid.obj_rom_data <= 12'h321;
    endcase
    vid.player_rom_data <= (vid.player_rom_addr[13:10] == 4'd2) ? ply_val : 12'hBAD;
  end

  task automatic drive(input logic [10:0] h, input logic [9:0] v,
                       input logic hs, input logic vs, input logic bl);
    vid.hcount = h;
    vid.vcount = v;
    vid.hsync  = hs;
    vid.vsync  = vs;
    vid.blank  = bl;
    @(posedge clock);
    #1;
  endtask

  // Present one visible pixel, then two blanked idles: outputs then show it.
  task automatic run_pixel(input logic [10:0] h, input logic [9:0] v);
    drive(h, v, 1'b1, 1'b1, 1'b0);
    drive(11'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    drive(11'd0, 10'd0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic latch_frame();
    drive(11'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    drive(11'd0, 10'd0, 1'b1, 1'b0, 1'b1);
    drive(11'd0, 10'd0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic set_cell(input int r, input int c, input logic [3:0] code);
    object_grid[(r*13+c)*4 +: 4] = code;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if (vid.pixel_out !== 12'h000) begin errors++; $display("FAIL rst_pix got %h exp 000", vid.pixel_out); end
    checks++; if (vid.hsync_out !== 1'b1) begin errors++; $display("FAIL rst_hs got %b exp 1", vid.hsync_out); end
    checks++; if (vid.vsync_out !== 1'b1) begin errors++; $display("FAIL rst_vs got %b exp 1", vid.vsync_out); end
    checks++; if (vid.blank_out !== 1'b1) begin errors++; $display("FAIL rst_bl got %b exp 1", vid.blank_out); end
    vid.hcount = 11'd112; vid.vcount = 10'd112; vid.hsync = 1'b0; vid.blank = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (vid.hsync_out !== 1'b1) begin errors++; $display("FAIL rst_hold_hs got %b exp 1", vid.hsync_out); end
    set_cell(0, 0, 4'd3);
    @(negedge clock) reset = 1'b0;
    run_pixel(11'd112, 10'd112);
    checks++; if (vid.pixel_out !== 12'h00A) begin errors++; $display("FAIL rst_empty_frame got %h exp 00A", vid.pixel_out); end
  endtask

  task automatic test_basic();
    latch_frame();
    drive(11'd112, 10'd112, 1'b0, 1'b1, 1'b0);
    drive(11'd600, 10'd112, 1'b1, 1'b1, 1'b0);
    checks++; if (vid.hsync_out !== 1'b1) begin errors++; $display("FAIL lat_early_hs got %b exp 1", vid.hsync_out); end
    drive(11'd600, 10'd112, 1'b1, 1'b1, 1'b1);
    checks++; if (vid.pixel_out !== 12'h123) begin errors++; $display("FAIL lat_pix got %h exp 123", vid.pixel_out); end
    checks++; if (vid.hsync_out !== 1'b0) begin errors++; $display("FAIL lat_hs got %b exp 0", vid.hsync_out); end
    checks++; if (vid.vsync_out !== 1'b1) begin errors++; $display("FAIL lat_vs got %b exp 1", vid.vsync_out); end
    checks++; if (vid.blank_out !== 1'b0) begin errors++; $display("FAIL lat_bl got %b exp 0", vid.blank_out); end
    drive(11'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    checks++; if (vid.pixel_out !== 12'h00A) begin errors++; $display("FAIL lat_next_pix got %h exp 00A", vid.pixel_out); end
    drive(11'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    checks++; if (vid.pixel_out !== 12'h000 || vid.blank_out !== 1'b1) begin
      errors++; $display("FAIL lat_blank got %h/%b exp 000/1", vid.pixel_out, vid.blank_out); end
    drive(11'd117, 10'd119, 1'b1, 1'b1, 1'b0);
    exp_addr = {4'd3, 5'd7, 5'd5};
    checks++; if (vid.obj_rom_addr !== exp_addr) begin errors++; $display("FAIL obj_addr got %h exp %h", vid.obj_rom_addr, exp_addr); end
  endtask

  task automatic test_mid_frame();
    drive(11'd0, 10'd300, 1'b1, 1'b1, 1'b1);
    set_cell(5, 0, 4'd6);
    set_cell(0, 0, 4'd6);
    run_pixel(11'd112, 10'd300);
    checks++; if (vid.pixel_out !== 12'h00A) begin errors++; $display("FAIL mid_r5 got %h exp 00A", vid.pixel_out); end
    run_pixel(11'd112, 10'd112);
    checks++; if (vid.pixel_out !== 12'h123) begin errors++; $display("FAIL mid_r0 got %h exp 123", vid.pixel_out); end
    latch_frame();
    run_pixel(11'd112, 10'd300);
    checks++; if (vid.pixel_out !== 12'h456) begin errors++; $display("FAIL new_r5 got %h exp 456", vid.pixel_out); end
    run_pixel(11'd112, 10'd112);
    checks++; if (vid.pixel_out !== 12'h456) begin errors++; $display("FAIL new_r0 got %h exp 456", vid.pixel_out); end
  endtask

  task automatic test_player();
    set_cell(0, 0, 4'd3);
    set_cell(5, 0, 4'd0);
    latch_frame();
    player_code = 4'd2; player_x = 11'd112; player_y = 10'd112; ply_val = 12'h0F0;
    run_pixel(11'd112, 10'd112);
    checks++; if (vid.pixel_out !== 12'h0F0) begin errors++; $display("FAIL ply_over got %h exp 0F0", vid.pixel_out); end
    drive(11'd117, 10'd119, 1'b1, 1'b1, 1'b0);
    exp_addr = {4'd2, 5'd7, 5'd5};
    checks++; if (vid.player_rom_addr !== exp_addr) begin errors++; $display("FAIL ply_addr got %h exp %h", vid.player_rom_addr, exp_addr); end
    ply_val = 12'hF0F;
    run_pixel(11'd112, 10'd112);
    checks++; if (vid.pixel_out !== 12'h123) begin errors++; $display("FAIL ply_key got %h exp 123", vid.pixel_out); end
    ply_val = 12'h0F0;
    run_pixel(11'd112, 10'd144);
    checks++; if (vid.pixel_out !== 12'h00A) begin errors++; $display("FAIL ply_below got %h exp 00A", vid.pixel_out); end
    player_x = 11'd100;
    run_pixel(11'd99, 10'd112);
    checks++; if (vid.pixel_out !== 12'h00A) begin errors++; $display("FAIL ply_left got %h exp 00A", vid.pixel_out); end
    run_pixel(11'd100, 10'd112);
    checks++; if (vid.pixel_out !== 12'h0F0) begin errors++; $display("FAIL ply_offgrid got %h exp 0F0", vid.pixel_out); end
    run_pixel(11'd132, 10'd112);
    checks++; if (vid.pixel_out !== 12'h123) begin errors++; $display("FAIL ply_right got %h exp 123", vid.pixel_out); end
    player_x = 11'd2040;
    run_pixel(11'd5, 10'd112);
    checks++; if (vid.pixel_out !== 12'h00A) begin errors++; $display("FAIL ply_nowrap got %h exp 00A", vid.pixel_out); end
    player_x = 11'd112;
    drive(11'd112, 10'd112, 1'b1, 1'b1, 1'b1);
    drive(11'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    drive(11'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    checks++; if (vid.pixel_out !== 12'h000) begin errors++; $display("FAIL ply_blank got %h exp 000", vid.pixel_out); end
    player_code = 4'd0;
    run_pixel(11'd112, 10'd112);
    checks++; if (vid.pixel_out !== 12'h123) begin errors++; $display("FAIL ply_none got %h exp 123", vid.pixel_out); end
  endtask

  task automatic test_edges();
    set_cell(0, 1, 4'd15);
    set_cell(0, 12, 4'd3);
    set_cell(7, 0, 4'd3);
    latch_frame();
    run_pixel(11'd144, 10'd112);
    checks++; if (vid.pixel_out !== 12'h00A) begin errors++; $display("FAIL code15 got %h exp 00A", vid.pixel_out); end
    run_pixel(11'd527, 10'd112);
    checks++; if (vid.pixel_out !== 12'h123) begin errors++; $display("FAIL x_last got %h exp 123", vid.pixel_out); end
    run_pixel(11'd528, 10'd112);
    checks++; if (vid.pixel_out !== 12'h00A) begin errors++; $display("FAIL x_edge got %h exp 00A", vid.pixel_out); end
    run_pixel(11'd111, 10'd112);
    checks++; if (vid.pixel_out !== 12'h00A) begin errors++; $display("FAIL x_before got %h exp 00A", vid.pixel_out); end
    run_pixel(11'd112, 10'd367);
    checks++; if (vid.pixel_out !== 12'h123) begin errors++; $display("FAIL y_last got %h exp 123", vid.pixel_out); end
    run_pixel(11'd112, 10'd368);
    checks++; if (vid.pixel_out !== 12'h00A) begin errors++; $display("FAIL y_edge got %h exp 00A", vid.pixel_out); end
  endtask

  task automatic test_timer_bar();
    time_grid[3:0] = 4'd5;
    latch_frame();
`ifdef GRID_TIMER_BAR_EN
    run_pixel(11'd121, 10'd142);
    checks++; if (vid.pixel_out !== 12'hFF0) begin errors++; $display("FAIL bar_in got %h exp FF0", vid.pixel_out); end
    run_pixel(11'd121, 10'd143);
    checks++; if (vid.pixel_out !== 12'hFF0) begin errors++; $display("FAIL bar_last_row got %h exp FF0", vid.pixel_out); end
    run_pixel(11'd122, 10'd142);
    checks++; if (vid.pixel_out !== 12'h123) begin errors++; $display("FAIL bar_end got %h exp 123", vid.pixel_out); end
    run_pixel(11'd112, 10'd141);
    checks++; if (vid.pixel_out !== 12'h123) begin errors++; $display("FAIL bar_above got %h exp 123", vid.pixel_out); end
`else
    run_pixel(11'd121, 10'd142);
    checks++; if (vid.pixel_out !== 12'h123) begin errors++; $display("FAIL nobar got %h exp 123", vid.pixel_out); end
`endif
    player_code = 4'd2; player_x = 11'd112; player_y = 10'd112; ply_val = 12'h0F0;
    run_pixel(11'd121, 10'd142);
    checks++; if (vid.pixel_out !== 12'h0F0) begin errors++; $display("FAIL bar_under_ply got %h exp 0F0", vid.pixel_out); end
    player_code = 4'd0;
  endtask

  task automatic test_reset_mid();
    drive(11'd112, 10'd112, 1'b0, 1'b1, 1'b0);
    drive(11'd112, 10'd112, 1'b0, 1'b1, 1'b0);
    drive(11'd112, 10'd112, 1'b0, 1'b1, 1'b0);
    checks++; if (vid.hsync_out !== 1'b0 || vid.pixel_out !== 12'h123) begin
      errors++; $display("FAIL pre_rst got %b/%h exp 0/123", vid.hsync_out, vid.pixel_out); end
    #2 reset = 1'b1;
    #1;
    checks++; if (vid.pixel_out !== 12'h000 || vid.hsync_out !== 1'b1 || vid.vsync_out !== 1'b1 || vid.blank_out !== 1'b1) begin
      errors++; $display("FAIL midrst got %h/%b/%b/%b exp 000/1/1/1", vid.pixel_out, vid.hsync_out, vid.vsync_out, vid.blank_out); end
    #2 reset = 1'b0;
    run_pixel(11'd112, 10'd112);
    checks++; if (vid.pixel_out !== 12'h00A) begin errors++; $display("FAIL midrst_bg got %h exp 00A", vid.pixel_out); end
    run_pixel(11'd527, 10'd112);
    checks++; if (vid.pixel_out !== 12'h00A) begin errors++; $display("FAIL midrst_bg2 got %h exp 00A", vid.pixel_out); end
  endtask

  initial begin
    vid.hcount = '0; vid.vcount = '0;
    vid.hsync = 1'b1; vid.vsync = 1'b1; vid.blank = 1'b1;
    object_grid = '0; time_grid = '0;
    player_x = '0; player_y = '0; player_code = '0;
    ply_val = 12'h0F0;
    test_reset();
    test_basic();
    test_mid_frame();
    test_player();
    test_edges();
    test_timer_bar();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_sprite_renderer.md
GRID_SPRITE_RENDERER -- requirements
Module: grid_sprite_renderer

Interface
REQ-001 SHALL have parameter GRID_COLS, default 13, meaning tile columns.
REQ-002 SHALL have parameter GRID_ROWS, default 8, meaning tile rows.
REQ-003 SHALL have parameter TILE_LOG2, default 5, meaning tile edge = 2^TILE_LOG2 pixels (32).
REQ-004 SHALL have parameters ORIGIN_X, default 112, and ORIGIN_Y, default 112, meaning grid top-left pixel.
REQ-005 SHALL have parameter NUM_SPRITES, default 16, meaning valid object codes 0..NUM_SPRITES-1, with 0 = empty.
REQ-006 SHALL have parameters KEY_COLOR, default 12'hF0F (transparent), and BG_COLOR, default 12'h000.
REQ-007 SHALL have ports: clock in 1 (pixel clock); reset in 1 (asynchronous, active-high).
REQ-008 SHALL have ports: hcount in 11; vcount in 10; hsync, vsync in 1 (active low); blank in 1 (1 = black).
REQ-009 SHALL have ports: object_grid and time_grid, each in GRID_ROWS*GRID_COLS*4, with cell (r,c) at bits [(r*GRID_COLS+c)*4 +: 4].
REQ-010 SHALL have ports: player_x in 11; player_y in 10; player_code in 4, where 0 = no player.
REQ-011 SHALL have ports: obj_rom_addr out 4+2*TILE_LOG2; obj_rom_data in 12 (one-cycle read latency). player_rom_addr and player_rom_data SHALL be identical in shape.
REQ-012 SHALL have ports: pixel_out out 12; hsync_out, vsync_out, blank_out out 1.

Function
REQ-013 SHALL latch object_grid and time_grid into frame registers on the cycle vsync goes 1->0; mid-frame input changes SHALL NOT be displayed until the next latch.
REQ-014 Stage 0 SHALL register in_grid, col, row and offsets for pixels in the window ORIGIN_X <= hcount < ORIGIN_X+GRID_COLS*2^TILE_LOG2 (same rule in y). Column and row are a shift by TILE_LOG2; offsets are the low TILE_LOG2 bits.
REQ-015 Stage 1 SHALL drive obj_rom_addr = {code, offy, offx} from the frame registers. Code 0, code >= NUM_SPRITES, or !in_grid SHALL mark the object as absent.
REQ-016 Stage 1 SHALL drive player_rom_addr = {player_code, vcount-player_y, hcount-player_x} (low TILE_LOG2 bits each), with the player present only inside its tile-sized box and player_code != 0.
REQ-017 Stage 2 compositing priority SHALL be: blank -> 12'h000; else player pixel if present and != KEY_COLOR; else object pixel if present and != KEY_COLOR; else BG_COLOR.
REQ-018 Total latency SHALL be exactly 3 clocks: pixel_out, hsync_out, vsync_out and blank_out all correspond to the hcount/vcount/sync inputs of 3 cycles earlier.
REQ-019 Player box partially off-grid or off-screen SHALL render only the visible portion, with no wrap: hcount < player_x means absent.
REQ-020 The last column/row edge (hcount = ORIGIN_X+GRID_COLS*2^TILE_LOG2) SHALL be outside the grid.

Reset
REQ-021 Asynchronous reset SHALL force: pixel_out=0, hsync_out=1, vsync_out=1, blank_out=1, all pipeline valid flags=0, and frame registers=0 (empty grid).
REQ-022 Reset deasserted mid-frame SHALL yield correct pixels 3 cycles later, using empty frame registers until the next vsync latch.

Configuration
REQ-023 Macro GRID_TIMER_BAR_EN defined: in the bottom 2 pixel rows of each in-grid tile, pixels with offx < 2*time value SHALL be 12'hFF0. The bar sits above the object and below the player.
REQ-024 Macro GRID_TIMER_BAR_EN undefined: time_grid SHALL be ignored (port kept), with no bar logic instantiated.

Structure
REQ-025 A shared package grid_gfx_pkg SHALL hold the object-code constants (G_EMPTY..G_EXTINGUISHER), the player-state codes, KEY_COLOR and the bar color.
REQ-026 One sub-module, grid_tile_locator, SHALL implement the stage-0 pixel-to-tile mapping, registered.

Verification
REQ-027 Reset mid-line -> outputs 0/1/1/1 immediately; after release with vsync still high, all in-grid pixels = BG_COLOR.
REQ-028 Cell (0,0)=code 3, ROM returns 12'h123 at addr {3,0,0}, vsync fall, then hcount=112, vcount=112 -> pixel_out=12'h123 exactly 3 clocks later, with syncs aligned.
REQ-029 object_grid changed at vcount=300 without a vsync -> remaining frame unchanged; new code displayed only after the next vsync fall.
REQ-030 Player code 2 at (112,112) over object code 3: player ROM 12'h0F0 -> 12'h0F0; player ROM KEY_COLOR -> object 12'h123.
REQ-031 Code 15 with NUM_SPRITES=8 -> treated as empty, giving BG_COLOR; hcount=528 (grid edge) -> BG_COLOR.
REQ-032 With GRID_TIMER_BAR_EN and time 5 in cell (0,0) -> pixels offy 30..31, offx 0..9 = 12'hFF0; offx 10 = object pixel.
